// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Holds the fetch FSM state encoding, the reset fetch address and the bit
// positions of the decoded instruction fields.

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no outstanding request
        ST_REQ  = 2'd1,   // requesting fetch_pc
        ST_DROP = 2'd2    // stale request in flight; its response is discarded
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    // FIFO entry is {instr[31:0], pc[31:0]}
    localparam int FIFO_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry FIFO holding fetched {instr, pc} pairs
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data write an entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push and pop
//   head_data       current head entry (valid when count != 0)
//   count           number of stored entries, 0..2

module fetch_fifo
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FIFO_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [FIFO_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [FIFO_W-1:0] mem [0:1];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push && !flush && (count != 2'd2);
    assign do_pop    = pop && !flush && (count != 2'd0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: entries are only observed when count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with 2-entry prefetch buffer
//
// Optional feature macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_req, imem_addr         registered instruction-memory read request
//   imem_ack, imem_rdata        read completion and returned word
//   instr_valid, instr_ready    head-of-buffer handshake to the control path
//   cond, op, funct, rd         fields decoded from the head instruction
//   instr_pc                    address of the head instruction
//   pc_src, branch_target       redirect request and target (bits [1:0] ignored)
//   perf_fetch_cnt              (FETCH_PERF_EN) count of consumed instructions
//   perf_flush_cnt              (FETCH_PERF_EN) count of redirect cycles

module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [31:0] instr_pc,
    input  logic        pc_src,
`ifdef FETCH_PERF_EN
    input  logic [31:0] branch_target,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`else
    input  logic [31:0] branch_target
`endif
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       addr_d;
    logic [31:0]       target;
    logic [31:0]       pc_plus4;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [1:0]        count_after;
    logic [FIFO_W-1:0] head_data;
    logic [31:0]       head_instr;
    logic              unused_target_bits;

    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];
    assign pc_plus4           = fetch_pc_q + 32'd4;

    // A redirect flushes the buffer, so it overrides both push and pop.
    assign pop  = instr_valid && instr_ready && !pc_src;
    assign push = (state_q == ST_REQ) && imem_ack && !pc_src;

    // Occupancy once this edge's push/pop/flush have taken effect. In REQ
    // the FIFO never holds more than one entry, so push cannot overflow it.
    assign count_after = pc_src ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});

    fetch_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({imem_rdata, fetch_pc_q}),
        .pop       (pop),
        .flush     (pc_src),
        .head_data (head_data),
        .count     (count)
    );

    assign instr_valid = (count != 2'd0);
    assign head_instr  = head_data[63:32];
    assign instr_pc    = head_data[31:0];
    assign cond        = head_instr[COND_HI:COND_LO];
    assign op          = head_instr[OP_HI:OP_LO];
    assign funct       = head_instr[FUNCT_HI:FUNCT_LO];
    assign rd          = head_instr[RD_HI:RD_LO];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = imem_addr;
        case (state_q)
            ST_IDLE: begin
                if (pc_src) begin
                    fetch_pc_d = target;
                    state_d    = ST_REQ;
                    addr_d     = target;
                end else if (count_after != 2'd2) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (pc_src) begin
                    fetch_pc_d = target;
                    if (imem_ack) begin
                        // Response lands now and is simply not pushed.
                        addr_d = target;
                    end else begin
                        // Old address stays on the bus until its ack drains.
                        state_d = ST_DROP;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = pc_plus4;
                    if (count_after == 2'd2) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = pc_plus4;
                    end
                end
            end
            ST_DROP: begin
                if (pc_src) begin
                    fetch_pc_d = target;
                end else if (imem_ack) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            imem_req   <= (state_d != ST_IDLE);
            imem_addr  <= addr_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 16'd0;
        end else begin
            if (pop)    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (pc_src) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [31:0] instr_pc;
    logic        pc_src;
    logic [31:0] branch_target;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int checks;
    int failures;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .instr_pc      (instr_pc),
        .pc_src        (pc_src),
`ifdef FETCH_PERF_EN
        .branch_target (branch_target),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`else
        .branch_target (branch_target)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released;
    // the next rising edge is the first one the design acts on.
    task automatic do_reset();
        reset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        pc_src = 1'b0;
        branch_target = 32'h0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        pc_src = 1'b0;
        branch_target = 32'h0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req_held got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        do_reset();
        instr_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL seq_addr0 got=%h exp=00000000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL seq_valid0 got=%b exp=0", instr_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr4 got=%h exp=00000004", imem_addr); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL seq_pc0 got=%b/%h exp=1/00000000", instr_valid, instr_pc); end
        imem_rdata = 32'h2222_0004;
        step();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr8 got=%h exp=00000008", imem_addr); end
        checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL seq_pc4 got=%h exp=00000004", instr_pc); end
        imem_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0000;
        step();
        step();
        imem_rdata = 32'hBBBB_0004;
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/00000000", instr_valid, instr_pc); end
        step();
        checks++; if (imem_req !== 1'b0 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_hold got=%b/%h exp=0/00000000", imem_req, instr_pc); end
        instr_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_resume got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL bp_next_pc got=%h exp=00000004", instr_pc); end
        imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_fields();
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'hE3A0_1005;
        step();
        imem_ack = 1'b0;
        checks++; if (cond !== 4'hE) begin failures++; $display("FAIL fld_cond got=%h exp=e", cond); end
        checks++; if (op !== 2'b00) begin failures++; $display("FAIL fld_op got=%b exp=00", op); end
        checks++; if (funct !== 6'h3A) begin failures++; $display("FAIL fld_funct got=%h exp=3a", funct); end
        checks++; if (rd !== 4'h1) begin failures++; $display("FAIL fld_rd got=%h exp=1", rd); end
    endtask

    task automatic test_drop();
        do_reset();
        instr_ready = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h0101_0101;
        step();
        step();
        step();
        imem_ack = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL drop_pre got=%b/%h exp=0/00000008", instr_valid, imem_addr); end
        pc_src = 1'b1; branch_target = 32'h0000_0103;
        step();
        pc_src = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL drop_stale got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drop_discard got=%b exp=0", instr_valid); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_target got=%h exp=00000100", imem_addr); end
        imem_ack = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drop_wait got=%b exp=0", instr_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL drop_land got=%b/%h exp=1/00000100", instr_valid, instr_pc); end
        checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL drop_next got=%h exp=00000104", imem_addr); end
        // Redirect again while unacked, then once more inside DROP.
        imem_ack = 1'b0; pc_src = 1'b1; branch_target = 32'h0000_0300;
        step();
        branch_target = 32'h0000_0400;
        step();
        pc_src = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_redir got=%b/%h/%b exp=1/00000104/0", imem_req, imem_addr, instr_valid); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h400 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_last_target got=%h/%b exp=00000400/0", imem_addr, instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_flush_ack();
        do_reset();
        instr_ready = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        step();
        step();
        pc_src = 1'b1; branch_target = 32'h0000_0200;
        step();
        pc_src = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL fa_empty got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL fa_target got=%b/%h exp=1/00000200", imem_req, imem_addr); end
        imem_rdata = 32'h5000_0000;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || cond !== 4'h5) begin failures++; $display("FAIL fa_land got=%b/%h/%h exp=1/00000200/5", instr_valid, instr_pc, cond); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        step();
        pc_src = 1'b1; branch_target = 32'hFFFF_FFFF; imem_ack = 1'b1;
        step();
        pc_src = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
        step();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        checks++; if (instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", instr_pc); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin failures++; $display("FAIL midreq_reset got=%b/%h/%b exp=0/00000000/0", imem_req, imem_addr, instr_valid); end
        step();
        reset = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_fields();
        test_drop();
        test_flush_ack();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
